// File: rtl/gate_share_arbiter.sv
// Two-requester round-robin arbiter that sequences operations through one shared
// external gate unit and returns each result with its requester ID.
module gate_share_arbiter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] gate_a,
    output logic [WIDTH-1:0] gate_b,
    output logic [2:0]       gate_op,
    input  logic [WIDTH-1:0] gate_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q;
    logic               rr_ptr_q;
    logic [WIDTH-1:0]   gate_a_q;
    logic [WIDTH-1:0]   gate_b_q;
    logic [2:0]         gate_op_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [CNT_W-1:0]   done_count_q;
    logic [CNT_W-1:0]   done_count_d;
    logic [1:0]         grant;
    logic               grant_id;

    // Grant is suppressed while reset is held so nothing is offered during reset.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && rst_n) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id     = grant[1];
    assign done_count_d = (done_count_q == {CNT_W{1'b1}}) ? done_count_q
                                                          : done_count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            gate_a_q     <= '0;
            gate_b_q     <= '0;
            gate_op_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            done_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        gate_a_q  <= grant_id ? req1_a  : req0_a;
                        gate_b_q  <= grant_id ? req1_b  : req0_b;
                        gate_op_q <= grant_id ? req1_op : req0_op;
                        rsp_id_q  <= grant_id;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data_q  <= gate_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // Priority flips to the other requester only once a response retires.
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        rr_ptr_q     <= ~rsp_id_q;
                        done_count_q <= done_count_d;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = grant;
    assign gate_a     = gate_a_q;
    assign gate_b     = gate_b_q;
    assign gate_op    = gate_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_count_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Bench for gate_share_arbiter (WIDTH=4, CNT_W=2): directed vector table, hand-written
// reset/backpressure sequences and randomized transactions against a transaction-level model.
module tb_gate_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic [3:0] gate_a, gate_b, gate_out;
    logic [2:0] gate_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_data;
    logic       busy;
    logic [1:0] done_count;

    int n_cmp = 0;
    int n_err = 0;
    int txn_no = 0;

    gate_share_arbiter #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .gate_a(gate_a), .gate_b(gate_b), .gate_op(gate_op), .gate_out(gate_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gate_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a ^ b);
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // External shared gate unit.
    assign gate_out = gate_fn(gate_a, gate_b, gate_op);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full operation: present request, expect grant, follow it through ISSUE and RESP.
    task automatic run_txn(input logic [1:0] v,
                           input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] o0,
                           input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] o1,
                           input int stall, input int exp_id,
                           input logic [3:0] exp_data, input logic [1:0] exp_done);
        logic [3:0] ea, eb;
        logic [2:0] eo;
        ea = (exp_id != 0) ? a1 : a0;
        eb = (exp_id != 0) ? b1 : b0;
        eo = (exp_id != 0) ? o1 : o0;
        req_valid = v;
        req0_a = a0; req0_b = b0; req0_op = o0;
        req1_a = a1; req1_b = b1; req1_op = o1;
        rsp_ready = (stall == 0);
        #1;
        chk("grant", 32'(req_ready), (exp_id != 0) ? 32'h2 : 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
        tick();
        chk("issue_busy", 32'(busy), 32'h1);
        chk("issue_ready", 32'(req_ready), 32'h0);
        chk("issue_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("gate_a", 32'(gate_a), 32'(ea));
        chk("gate_b", 32'(gate_b), 32'(eb));
        chk("gate_op", 32'(gate_op), 32'(eo));
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rsp_id", 32'(rsp_id), 32'(exp_id));
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'h1);
            chk("stall_id", 32'(rsp_id), 32'(exp_id));
            chk("stall_data", 32'(rsp_data), 32'(exp_data));
            chk("stall_ready", 32'(req_ready), 32'h0);
            chk("stall_busy", 32'(busy), 32'h1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("done_valid", 32'(rsp_valid), 32'h0);
        chk("done_busy", 32'(busy), 32'h0);
        chk("done_count", 32'(done_count), 32'(exp_done));
        chk("gate_hold", 32'(gate_a), 32'(ea));
        $display("txn %0d: valid=%b id=%0d data=%h stall=%0d done=%0d", txn_no, v, exp_id,
                 exp_data, stall, exp_done);
        txn_no++;
        req_valid = 2'b00;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [3:0] a0, b0;
        logic [2:0] o0;
        logic [3:0] a1, b1;
        logic [2:0] o1;
        int         stall;
        int         id;
        logic [3:0] data;
        logic [1:0] done;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         rr_m;
        int         n_done_m;
        logic [1:0] v;
        logic [3:0] a0, b0, a1, b1;
        logic [2:0] o0, o1;
        int         st, id;

        tbl[0] = '{2'b11, 4'hC, 4'hA, 3'd0, 4'hC, 4'hA, 3'd1, 0, 0, 4'h8, 2'd1};
        tbl[1] = '{2'b11, 4'hC, 4'hA, 3'd0, 4'hC, 4'hA, 3'd1, 0, 1, 4'hE, 2'd2};
        tbl[2] = '{2'b11, 4'hC, 4'hA, 3'd0, 4'hC, 4'hA, 3'd1, 0, 0, 4'h8, 2'd3};
        tbl[3] = '{2'b11, 4'hC, 4'hA, 3'd0, 4'hC, 4'hA, 3'd1, 0, 1, 4'hE, 2'd3};
        tbl[4] = '{2'b01, 4'hC, 4'hA, 3'd3, 4'h0, 4'h0, 3'd0, 0, 0, 4'h9, 2'd3};
        tbl[5] = '{2'b10, 4'h0, 4'h0, 3'd0, 4'h5, 4'h3, 3'd4, 0, 1, 4'hE, 2'd3};
        tbl[6] = '{2'b11, 4'hF, 4'h0, 3'd2, 4'h6, 4'h0, 3'd6, 5, 0, 4'hF, 2'd3};
        tbl[7] = '{2'b11, 4'hF, 4'h0, 3'd2, 4'h6, 4'h0, 3'd6, 0, 1, 4'h9, 2'd3};
        tbl[8] = '{2'b01, 4'hA, 4'h0, 3'd7, 4'h0, 4'h0, 3'd0, 0, 0, 4'hA, 2'd3};

        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gate_a", 32'(gate_a), 32'h0);
        chk("rst_gate_b", 32'(gate_b), 32'h0);
        chk("rst_gate_op", 32'(gate_op), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_done", 32'(done_count), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("release_grant", 32'(req_ready), 32'h1);
        req_valid = 2'b00;

        foreach (tbl[i])
            run_txn(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].o0, tbl[i].a1, tbl[i].b1,
                    tbl[i].o1, tbl[i].stall, tbl[i].id, tbl[i].data, tbl[i].done);

        // A request that appears during RESP and is withdrawn before completion leaves no trace.
        req_valid = 2'b01; req0_a = 4'h3; req0_b = 4'h3; req0_op = 3'd2; rsp_ready = 1'b0;
        #1;
        chk("drop_grant", 32'(req_ready), 32'h1);
        tick();
        tick();
        chk("drop_rsp_data", 32'(rsp_data), 32'h0);
        req_valid = 2'b10;
        #1;
        chk("drop_ready_resp", 32'(req_ready), 32'h0);
        tick();
        req_valid = 2'b00; rsp_ready = 1'b1;
        tick();
        chk("drop_done_valid", 32'(rsp_valid), 32'h0);
        chk("drop_done_count", 32'(done_count), 32'h3);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drop_idle_busy", 32'(busy), 32'h0);
            chk("drop_idle_ready", 32'(req_ready), 32'h0);
        end

        // Reset while a response is pending drops it and restores requester-0 priority.
        req_valid = 2'b10; req1_a = 4'h3; req1_b = 4'h5; req1_op = 3'd0; rsp_ready = 1'b0;
        #1;
        chk("mid_grant", 32'(req_ready), 32'h2);
        tick();
        tick();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0; req_valid = 2'b00;
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_done", 32'(done_count), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
        end
        run_txn(2'b11, 4'hC, 4'hA, 3'd1, 4'h3, 4'h5, 3'd0, 1, 0, 4'hE, 2'd1);

        // Randomized transactions against a transaction-level model.
        rr_m = 1;
        n_done_m = 1;
        for (int t = 0; t < 40; t++) begin
            v  = 2'($urandom_range(1, 3));
            a0 = 4'($urandom); b0 = 4'($urandom); o0 = 3'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); o1 = 3'($urandom);
            st = int'($urandom_range(0, 3));
            id = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : rr_m;
            n_done_m++;
            run_txn(v, a0, b0, o0, a1, b1, o1, st, id,
                    (id != 0) ? gate_fn(a1, b1, o1) : gate_fn(a0, b0, o0),
                    (n_done_m > 3) ? 2'd3 : 2'(n_done_m));
            rr_m = 1 - id;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
